// File: rtl/rob_recovery_ctrl.sv
// ROB recovery sequencer: after a mispredict, squashes younger entries (two per cycle,
// youngest first), replays head..branch to rebuild rename state, then restores the tail.
module rob_recovery_ctrl #(
   parameter int ROB_DEPTH = 16,
   localparam int PTR_W = $clog2(ROB_DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mispredict_valid,
   input  logic [PTR_W-1:0]   mispredict_idx,
   input  logic [PTR_W-1:0]   rob_head,
   input  logic [PTR_W-1:0]   rob_tail,
   output logic               mispredict_ready,
   output logic [1:0]         rob_state,
   output logic               flush_valid,
   output logic [1:0]         rb_valid,
   output logic [2*PTR_W-1:0] rb_idx,
   output logic [1:0]         walk_valid,
   output logic [2*PTR_W-1:0] walk_idx,
   output logic               tail_restore_valid,
   output logic [PTR_W-1:0]   tail_restore
);

   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ROLLBACK = 2'b01,
      ST_WALK     = 2'b10
   } state_t;

   state_t           state;
   logic             flush_q;
   logic [PTR_W-1:0] br_idx;
   logic [PTR_W-1:0] rb_ptr;
   logic [CNT_W-1:0] rb_cnt;
   logic [PTR_W-1:0] walk_ptr;
   logic [CNT_W-1:0] walk_cnt;

   logic [PTR_W-1:0] rb_cnt_new;
   logic [PTR_W-1:0] walk_dist;
   logic [CNT_W-1:0] rb_step;
   logic [CNT_W-1:0] walk_step;

   // Counts wrap naturally in PTR_W bits, so a full ROB (head==tail) needs no special case;
   // the +1 on the walk distance is done in CNT_W bits so a full walk reads as ROB_DEPTH.
   assign rb_cnt_new = rob_tail - mispredict_idx - PTR_W'(1);
   assign walk_dist  = mispredict_idx - rob_head;
   assign rb_step    = (rb_cnt >= CNT_W'(2)) ? CNT_W'(2) : CNT_W'(1);
   assign walk_step  = (walk_cnt >= CNT_W'(2)) ? CNT_W'(2) : CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         flush_q  <= 1'b0;
         br_idx   <= '0;
         rb_ptr   <= '0;
         rb_cnt   <= '0;
         walk_ptr <= '0;
         walk_cnt <= '0;
      end else begin
         flush_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mispredict_valid) begin
                  br_idx   <= mispredict_idx;
                  rb_ptr   <= rob_tail - PTR_W'(1);
                  rb_cnt   <= {1'b0, rb_cnt_new};
                  walk_ptr <= rob_head;
                  walk_cnt <= {1'b0, walk_dist} + CNT_W'(1);
                  flush_q  <= 1'b1;
                  state    <= (rb_cnt_new != '0) ? ST_ROLLBACK : ST_WALK;
               end
            end
            ST_ROLLBACK: begin
               rb_ptr <= rb_ptr - PTR_W'(2);
               rb_cnt <= rb_cnt - rb_step;
               if (rb_cnt <= CNT_W'(2))
                  state <= ST_WALK;
            end
            ST_WALK: begin
               walk_ptr <= walk_ptr + PTR_W'(2);
               walk_cnt <= walk_cnt - walk_step;
               if (walk_cnt <= CNT_W'(2))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Every output below decodes registered state only; indices are zeroed outside their phase.
   assign rob_state          = state;
   assign mispredict_ready   = (state == ST_IDLE);
   assign flush_valid        = flush_q;
   assign rb_valid           = (state != ST_ROLLBACK) ? 2'b00 :
                               (rb_cnt >= CNT_W'(2)) ? 2'b11 : 2'b01;
   assign rb_idx             = (state == ST_ROLLBACK) ? {rb_ptr - PTR_W'(1), rb_ptr} : '0;
   assign walk_valid         = (state != ST_WALK) ? 2'b00 :
                               (walk_cnt >= CNT_W'(2)) ? 2'b11 : 2'b01;
   assign walk_idx           = (state == ST_WALK) ? {walk_ptr + PTR_W'(1), walk_ptr} : '0;
   assign tail_restore_valid = (state == ST_WALK) && (walk_cnt <= CNT_W'(2));
   assign tail_restore       = tail_restore_valid ? br_idx + PTR_W'(1) : '0;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Self-checking bench for rob_recovery_ctrl: a list-based model of the squash and replay
// sequences predicts every cycle of each recovery; directed scenarios plus random ones.
module tb_rob_recovery_ctrl;

   localparam int DEPTH = 16;
   localparam int PW    = 4;

   logic          clk;
   logic          reset;
   logic          mispredict_valid;
   logic [PW-1:0] mispredict_idx;
   logic [PW-1:0] rob_head;
   logic [PW-1:0] rob_tail;
   logic          mispredict_ready;
   logic [1:0]    rob_state;
   logic          flush_valid;
   logic [1:0]    rb_valid;
   logic [2*PW-1:0] rb_idx;
   logic [1:0]    walk_valid;
   logic [2*PW-1:0] walk_idx;
   logic          tail_restore_valid;
   logic [PW-1:0] tail_restore;

   int checkCount;
   int errorCount;

   typedef struct {
      int st;
      int ready;
      int flush;
      int rbv;
      int rbi;
      int wv;
      int wi;
      int trv;
      int tr;
   } row_t;

   rob_recovery_ctrl #(.ROB_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .mispredict_valid   (mispredict_valid),
      .mispredict_idx     (mispredict_idx),
      .rob_head           (rob_head),
      .rob_tail           (rob_tail),
      .mispredict_ready   (mispredict_ready),
      .rob_state          (rob_state),
      .flush_valid        (flush_valid),
      .rb_valid           (rb_valid),
      .rb_idx             (rb_idx),
      .walk_valid         (walk_valid),
      .walk_idx           (walk_idx),
      .tail_restore_valid (tail_restore_valid),
      .tail_restore       (tail_restore)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int wrap(input int v);
      return ((v % DEPTH) + DEPTH) % DEPTH;
   endfunction

   function automatic row_t idleRow();
      row_t r;
      r.st = 0; r.ready = 1; r.flush = 0; r.rbv = 0; r.rbi = 0;
      r.wv = 0; r.wi = 0; r.trv = 0; r.tr = 0;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkRow(input row_t r, input string tag);
      checkOutput({tag, ".state"}, int'(rob_state), r.st);
      checkOutput({tag, ".ready"}, int'(mispredict_ready), r.ready);
      checkOutput({tag, ".flush"}, int'(flush_valid), r.flush);
      checkOutput({tag, ".rb_valid"}, int'(rb_valid), r.rbv);
      checkOutput({tag, ".rb_idx"}, int'(rb_idx), r.rbi);
      checkOutput({tag, ".walk_valid"}, int'(walk_valid), r.wv);
      checkOutput({tag, ".walk_idx"}, int'(walk_idx), r.wi);
      checkOutput({tag, ".tr_valid"}, int'(tail_restore_valid), r.trv);
      checkOutput({tag, ".tr"}, int'(tail_restore), r.tr);
   endtask

   // The model lists the squashed entries (youngest first) and the replayed entries
   // (oldest first), then deals them out two per cycle.
   task automatic buildRows(input int head, input int tail, input int idx, output row_t rows[$]);
      int squashList[$];
      int walkList[$];
      int nRb;
      int nWalk;
      bit first;
      row_t r;
      rows = {};
      nRb = wrap(tail - idx - 1);
      nWalk = wrap(idx - head) + 1;
      for (int k = 0; k < nRb; k++) squashList.push_back(wrap(tail - 1 - k));
      for (int k = 0; k < nWalk; k++) walkList.push_back(wrap(head + k));
      first = 1'b1;
      for (int k = 0; k < squashList.size(); k += 2) begin
         r = idleRow();
         r.st = 1; r.ready = 0; r.flush = first ? 1 : 0;
         r.rbv = (squashList.size() - k >= 2) ? 3 : 1;
         r.rbi = wrap(squashList[k] - 1) * DEPTH + squashList[k];
         rows.push_back(r);
         first = 1'b0;
      end
      for (int k = 0; k < walkList.size(); k += 2) begin
         r = idleRow();
         r.st = 2; r.ready = 0; r.flush = first ? 1 : 0;
         r.wv = (walkList.size() - k >= 2) ? 3 : 1;
         r.wi = wrap(walkList[k] + 1) * DEPTH + walkList[k];
         if (k + 2 >= walkList.size()) begin
            r.trv = 1;
            r.tr = wrap(idx + 1);
         end
         rows.push_back(r);
         first = 1'b0;
      end
      rows.push_back(idleRow());
   endtask

   // dropMode: 0 quiet while busy, 1 hold a bogus mispredict while busy, 2 random bogus requests
   task automatic applyStimulus(input string name, input int head, input int tail, input int idx,
                                input int dropMode, input int rowLimit);
      row_t rows[$];
      int limit;
      buildRows(head, tail, idx, rows);
      limit = (rowLimit >= 0 && rowLimit < rows.size()) ? rowLimit : rows.size();
      @(negedge clk);
      checkOutput({name, ".ready_pre"}, int'(mispredict_ready), 1);
      rob_head = PW'(head);
      rob_tail = PW'(tail);
      mispredict_idx = PW'(idx);
      mispredict_valid = 1'b1;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         checkRow(rows[k], $sformatf("%s.c%0d", name, k + 1));
         if (rows[k].st != 0 && dropMode != 0) begin
            mispredict_valid = (dropMode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            mispredict_idx = PW'($urandom_range(0, DEPTH - 1));
            rob_head = PW'($urandom_range(0, DEPTH - 1));
            rob_tail = PW'($urandom_range(0, DEPTH - 1));
         end else begin
            mispredict_valid = 1'b0;
         end
      end
      mispredict_valid = 1'b0;
   endtask

   initial begin
      int h;
      int n;
      checkCount = 0;
      errorCount = 0;
      reset = 1'b1;
      mispredict_valid = 1'b0;
      mispredict_idx = '0;
      rob_head = '0;
      rob_tail = '0;
      #1;
      checkRow(idleRow(), "reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      applyStimulus("normal", 2, 9, 5, 0, -1);
      applyStimulus("noyounger", 0, 4, 3, 0, -1);
      applyStimulus("wrap", 14, 3, 1, 0, -1);
      applyStimulus("full", 4, 4, 3, 0, -1);
      applyStimulus("busydrop", 2, 9, 5, 1, -1);

      applyStimulus("midwalk", 4, 4, 3, 0, 3);
      #2;
      reset = 1'b1;
      #1;
      checkRow(idleRow(), "asyncreset");
      @(negedge clk);
      checkRow(idleRow(), "resetheld");
      reset = 1'b0;
      applyStimulus("afterreset", 0, 1, 0, 0, -1);

      for (int t = 0; t < 40; t++) begin
         h = $urandom_range(0, DEPTH - 1);
         n = $urandom_range(1, DEPTH);
         applyStimulus($sformatf("rand%0d", t), h, wrap(h + n),
                       wrap(h + $urandom_range(0, n - 1)), 2, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
